// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/sub accumulator slice.
// Holds the FSM state enum, the op encoding and the select-width helper.
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Channel-select width: at least one bit even for a single channel.
  function automatic int sel_width(input int num_ops);
    return (num_ops > 1) ? $clog2(num_ops) : 1;
  endfunction

endpackage

// File: rtl/addsub_alu.sv
// Combinational signed add/sub with overflow detection at WIDTH+1 bits.
// Define ADDSUB_ACCUM_SATURATE_EN to clamp on overflow instead of wrapping.
module addsub_alu
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    sub,
  output logic signed [WIDTH-1:0] y,
  output logic                    ovf
);

  logic signed [WIDTH:0] a_x;
  logic signed [WIDTH:0] b_x;
  logic signed [WIDTH:0] sum_x;

  assign a_x   = (WIDTH+1)'(a);
  assign b_x   = (WIDTH+1)'(b);
  assign sum_x = (sub == OP_SUB) ? (a_x - b_x) : (a_x + b_x);

  // The extended sum cannot itself overflow; disagreement of its top two bits
  // means the true result lies outside the WIDTH-bit signed range.
  assign ovf = sum_x[WIDTH] ^ sum_x[WIDTH-1];

`ifdef ADDSUB_ACCUM_SATURATE_EN
  function automatic logic signed [WIDTH-1:0] sat_clamp(input logic signed [WIDTH:0] s);
    if (s[WIDTH])
      return {1'b1, {(WIDTH-1){1'b0}}};
    else
      return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  assign y = ovf ? sat_clamp(sum_x) : sum_x[WIDTH-1:0];
`else
  assign y = sum_x[WIDTH-1:0];
`endif

endmodule

// File: rtl/addsub_accum.sv
// Sequenced signed accumulator: start loads init_val, each accepted command adds or
// subtracts a selected operand channel, cmd_last hands the result out. Saturation via ADDSUB_ACCUM_SATURATE_EN.
module addsub_accum
  import addsub_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_OPS = 3,
  parameter int CNT_W   = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic [WIDTH-1:0]                init_val,
  input  logic [NUM_OPS*WIDTH-1:0]        opnd,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [sel_width(NUM_OPS)-1:0]   cmd_sel,
  input  logic                            cmd_sub,
  input  logic                            cmd_last,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [WIDTH-1:0]                result,
  output logic                            ovf,
  output logic [CNT_W-1:0]                step_cnt,
  output logic                            busy
);

  localparam int SEL_W = sel_width(NUM_OPS);

  state_t                   state;
  logic signed [WIDTH-1:0]  acc_p1;
  logic                     ovf_p1;
  logic [CNT_W-1:0]         step_p1;
  logic                     res_valid_q;
  logic                     busy_q;

  logic                     vld_p0;
  logic signed [WIDTH-1:0]  operand_p0;
  logic signed [WIDTH-1:0]  sum_p0;
  logic                     ovf_p0;

  // Stage 0: operand select and add/sub of the command being accepted
  assign cmd_ready = (state == ST_RUN);
  assign vld_p0    = cmd_valid & cmd_ready;

  // Out-of-range selects fall through to a zero operand.
  always_comb begin
    operand_p0 = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      if (cmd_sel == SEL_W'(k))
        operand_p0 = opnd[k*WIDTH +: WIDTH];
    end
  end

  addsub_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a   (acc_p1),
    .b   (operand_p0),
    .sub (cmd_sub),
    .y   (sum_p0),
    .ovf (ovf_p0)
  );

  // Stage 1: accumulator, sticky flag, step counter and sequencing FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      acc_p1      <= '0;
      ovf_p1      <= 1'b0;
      step_p1     <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc_p1  <= init_val;
            ovf_p1  <= 1'b0;
            step_p1 <= '0;
            busy_q  <= 1'b1;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (vld_p0) begin
            acc_p1 <= sum_p0;
            ovf_p1 <= ovf_p1 | ovf_p0;
            if (step_p1 != {CNT_W{1'b1}})
              step_p1 <= step_p1 + 1'b1;
            if (cmd_last) begin
              res_valid_q <= 1'b1;
              state       <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign result    = acc_p1;
  assign ovf       = ovf_p1;
  assign step_cnt  = step_p1;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_addsub_accum.sv
// Scoreboard bench for addsub_accum (WIDTH=8, NUM_OPS=3, CNT_W=4).
// Stimulus pushes expected results; a monitor pops them on each result handshake.
module tb_addsub_accum;

  localparam int WIDTH   = 8;
  localparam int NUM_OPS = 3;
  localparam int CNT_W   = 4;
  localparam int STEP_MAX = (1 << CNT_W) - 1;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     start;
  logic [WIDTH-1:0]         init_val;
  logic [NUM_OPS*WIDTH-1:0] opnd;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [1:0]               cmd_sel;
  logic                     cmd_sub;
  logic                     cmd_last;
  logic                     res_valid;
  logic                     res_ready;
  logic [WIDTH-1:0]         result;
  logic                     ovf;
  logic [CNT_W-1:0]         step_cnt;
  logic                     busy;

  addsub_accum #(
    .WIDTH   (WIDTH),
    .NUM_OPS (NUM_OPS),
    .CNT_W   (CNT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .init_val  (init_val),
    .opnd      (opnd),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_sel   (cmd_sel),
    .cmd_sub   (cmd_sub),
    .cmd_last  (cmd_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .ovf       (ovf),
    .step_cnt  (step_cnt),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int res;
    int ov;
    int step;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state: plain integers following the arithmetic rules
  int m_acc;
  int m_ovf;
  int m_step;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sres();
    return int'($signed(result));
  endfunction

  function automatic int to_range(input int s);
`ifdef ADDSUB_ACCUM_SATURATE_EN
    if (s > 127)  return 127;
    if (s < -128) return -128;
    return s;
`else
    return ((s + 128) % 256 + 256) % 256 - 128;
`endif
  endfunction

  // Result monitor: every completed result handshake must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && res_valid && res_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          check("sb_result", sres(), e.res);
          check("sb_ovf", int'(ovf), e.ov);
          check("sb_step", int'(step_cnt), e.step);
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_cmd_ready", int'(cmd_ready), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_result", sres(), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_step", int'(step_cnt), 0);
  endtask

  task automatic start_seq(input int init);
    start    = 1'b1;
    init_val = init[7:0];
    @(posedge clock); #1;
    start = 1'b0;
    m_acc  = init;
    m_ovf  = 0;
    m_step = 0;
    check("start_busy", int'(busy), 1);
    check("start_cmd_ready", int'(cmd_ready), 1);
    check("start_result", sres(), m_acc);
    check("start_ovf", int'(ovf), 0);
    check("start_step", int'(step_cnt), 0);
  endtask

  task automatic issue_cmd(input int sel, input int sub, input int last,
                           input int c0, input int c1, input int c2, input int gap);
    int ch[3];
    int op;
    int s;
    ch[0] = c0; ch[1] = c1; ch[2] = c2;
    for (int k = 0; k < NUM_OPS; k++) opnd[k*WIDTH +: WIDTH] = ch[k][7:0];
    cmd_sel   = sel[1:0];
    cmd_sub   = sub[0];
    cmd_last  = last[0];
    cmd_valid = 1'b1;
    op = (sel < NUM_OPS) ? ch[sel] : 0;
    s  = (sub != 0) ? m_acc - op : m_acc + op;
    if (s > 127 || s < -128) m_ovf = 1;
    m_acc  = to_range(s);
    m_step = (m_step < STEP_MAX) ? m_step + 1 : STEP_MAX;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
    if (last != 0) begin
      sb.push_back('{res: m_acc, ov: m_ovf, step: m_step});
    end else begin
      check("acc_step", sres(), m_acc);
      for (int g = 0; g < gap; g++) begin
        opnd    = NUM_OPS*WIDTH'($urandom);
        cmd_sel = 2'($urandom);
        cmd_sub = 1'($urandom);
        @(posedge clock); #1;
        check("gap_hold", sres(), m_acc);
        check("gap_step", int'(step_cnt), m_step);
      end
    end
  endtask

  // Wait for DONE, hold res_ready low while pulsing start, then consume
  task automatic finish_seq(input int hold);
    int t = 0;
    int held;
    while (!res_valid && t < 10) begin
      @(posedge clock); #1;
      t++;
    end
    check("done_timeout", int'(res_valid), 1);
    if (!res_valid) return;
    held = sres();
    for (int i = 0; i < hold; i++) begin
      start    = 1'b1;
      init_val = 8'($urandom);
      @(posedge clock); #1;
      check("hold_valid", int'(res_valid), 1);
      check("hold_result", sres(), held);
      check("hold_cmd_ready", int'(cmd_ready), 0);
    end
    start     = 1'b0;
    res_ready = 1'b1;
    @(posedge clock); #1;
    res_ready = 1'b0;
    check("idle_busy", int'(busy), 0);
    check("idle_valid", int'(res_valid), 0);
    check("idle_result", sres(), m_acc);
    check("idle_ovf", int'(ovf), m_ovf);
    check("idle_step", int'(step_cnt), m_step);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; init_val = '0; opnd = '0;
    cmd_valid = 1'b0; cmd_sel = '0; cmd_sub = 1'b0; cmd_last = 1'b0; res_ready = 1'b0;
    m_acc = 0; m_ovf = 0; m_step = 0;
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    // 10 +5 -(-3) -4 = 14, result valid right after the third accepted command
    start_seq(10);
    issue_cmd(0, 0, 0, 5, -3, 4, 0);
    issue_cmd(1, 1, 0, 5, -3, 4, 0);
    issue_cmd(2, 1, 1, 5, -3, 4, 0);
    check("latency_valid", int'(res_valid), 1);
    check("basic_result", sres(), 14);
    finish_seq(0);

    // Positive overflow, long DONE hold with start pulses
    start_seq(100);
    issue_cmd(0, 0, 1, 100, 0, 0, 0);
    finish_seq(5);

    // Negative overflow
    start_seq(-128);
    issue_cmd(0, 1, 1, 1, 0, 0, 0);
    finish_seq(1);

    // Reset in the middle of a run, then a clean run
    start_seq(7);
    issue_cmd(0, 0, 0, 20, 30, 40, 0);
    issue_cmd(1, 0, 0, 20, 30, 40, 0);
    do_reset();
    start_seq(-5);
    issue_cmd(2, 0, 1, 1, 2, 3, 0);
    finish_seq(0);

    // Gaps and an out-of-range select
    start_seq(33);
    issue_cmd(0, 0, 0, 9, 8, 7, 3);
    issue_cmd(3, 0, 0, 9, 8, 7, 2);
    issue_cmd(3, 1, 0, 9, 8, 7, 1);
    issue_cmd(1, 1, 1, 9, 8, 7, 0);
    finish_seq(2);

    // Randomized sequences, some long enough to saturate the step counter
    for (int s = 0; s < 25; s++) begin
      int n;
      start_seq(int'($urandom_range(0, 255)) - 128);
      n = int'($urandom_range(1, 18));
      for (int i = 0; i < n; i++) begin
        issue_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                  (i == n - 1) ? 1 : 0,
                  int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 255)) - 128,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
      end
      finish_seq(int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clock);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_accum.md
ADDSUB_ACCUM -- requirements
Module: addsub_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/accumulator width in bits, signed two's complement, legal range 2..32.
REQ-002 SHALL have parameter NUM_OPS, default 3, number of operand channels, legal range 1..8.
REQ-003 SHALL have parameter CNT_W, default 4, width of the step counter.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  begin a sequence; sampled only in IDLE.
REQ-007 init_val  input  WIDTH  initial accumulator value, captured with start.
REQ-008 opnd  input  NUM_OPS*WIDTH  flattened operand channels; channel k at bits [k*WIDTH +: WIDTH].
REQ-009 cmd_valid  input  1  command present.
REQ-010 cmd_ready  output  1  command accepted this cycle when both valid and ready are high.
REQ-011 cmd_sel  input  max(1,clog2(NUM_OPS))  operand channel select.
REQ-012 cmd_sub  input  1  1 = subtract, 0 = add.
REQ-013 cmd_last  input  1  final command of the sequence.
REQ-014 res_valid  output  1  result available.
REQ-015 res_ready  input  1  result consumed when both res_valid and res_ready are high.
REQ-016 result  output  WIDTH  accumulator value.
REQ-017 ovf  output  1  sticky signed-overflow flag for the current sequence.
REQ-018 step_cnt  output  CNT_W  number of commands accepted in the current sequence; saturates at all-ones.
REQ-019 busy  output  1  high whenever state is not IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, RUN, DONE.
REQ-021 IDLE: start=1 SHALL load acc=init_val, clear ovf and step_cnt, and enter RUN at the next edge.
REQ-022 start SHALL be ignored in RUN and DONE.
REQ-023 cmd_ready SHALL be 1 exactly in RUN, combinationally from state only.
REQ-024 Accepted command SHALL update acc = acc +/- opnd[cmd_sel] at the next edge (one-cycle latency), with a new command acceptable every cycle.
REQ-025 cmd_sel >= NUM_OPS SHALL use an operand of 0 and still count as a step.
REQ-026 Arithmetic SHALL be computed at WIDTH+1 bits; overflow SHALL be detected when the two top bits differ, setting ovf until the next start or reset.
REQ-027 Without saturation, acc SHALL take the low WIDTH bits (wrap-around).
REQ-028 An accepted command with cmd_last=1 SHALL apply its operation and enter DONE at the same edge.
REQ-029 DONE: res_valid=1 and result=acc SHALL be held stable until res_ready=1, then the block SHALL return to IDLE at the next edge.
REQ-030 result SHALL show acc in every state; ovf and step_cnt SHALL hold their values in IDLE until the next start.

Reset
REQ-031 reset SHALL force state=IDLE, acc=0, ovf=0, step_cnt=0, res_valid=0, cmd_ready=0, busy=0 at the next edge, overriding any handshake in progress, including mid-RUN and mid-DONE.

Configuration
REQ-032 Macro ADDSUB_ACCUM_SATURATE_EN defined: on overflow, acc SHALL clamp to +2^(WIDTH-1)-1 or -2^(WIDTH-1) according to the sign of the (WIDTH+1)-bit sum; ovf SHALL still be set.
REQ-033 Macro undefined: wrap-around per REQ-027; no saturation logic SHALL be synthesised.

Structure
REQ-034 The FSM state enum and the op encoding constants (OP_ADD=0, OP_SUB=1) SHALL live in the shared package addsub_pkg.
REQ-035 The combinational add/sub with overflow detection and optional clamp SHALL be a sub-module, addsub_alu, parametrised by WIDTH.

Verification (WIDTH=8, NUM_OPS=3)
REQ-036 init 10; cmds +ch0(5), -ch1(-3), last -ch2(4) on consecutive cycles -> DONE 3 cycles after the first command; result=14, ovf=0, step_cnt=3.
REQ-037 init 100; last +ch0(100) -> result=-56 and ovf=1; with SATURATE_EN, result=127 and ovf=1.
REQ-038 init -128; last -ch0(1) -> result=127 wrapped or -128 saturated; ovf=1.
REQ-039 res_ready held low for 5 cycles in DONE -> res_valid and result stable; start pulses during DONE ignored; IDLE the cycle after res_ready=1.
REQ-040 reset asserted after 2 commands in RUN -> next cycle IDLE, acc=0, step_cnt=0, cmd_ready=0; a new start then runs normally.
REQ-041 cmd_valid gaps between commands and cmd_sel=3 -> gaps produce no update; cmd_sel=3 adds 0 and increments step_cnt.
